// File: rtl/memory_arbiter.sv
// Arbiter sharing one RAM port between fetch and data requesters.
// Optional MEM_ARB_STATS_EN adds per-port completion counters.
module memory_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              iwait,
  output logic              dwait,
  output logic [DATA_W-1:0] iload,
  output logic [DATA_W-1:0] dload,
  output logic              ram_REN,
  output logic              ram_WEN,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_store,
  input  logic [DATA_W-1:0] ram_load,
  input  logic [1:0]        ram_state,
  output logic              mem_err,
  output logic [31:0]       iaccess_cnt,
  output logic [31:0]       daccess_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;
  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

  state_t          state;
  logic [WD_W-1:0] wd;

  logic req_d;
  logic acc;
  logic greq;
  logic i_done;
  logic d_done;

  always_comb begin
    req_d  = dREN | dWEN;
    acc    = (ram_state == RS_ACCESS);
    greq   = (state == IACC) ? iREN : req_d;
    i_done = (state == IACC) & acc & iREN;
    d_done = (state == DACC) & acc & req_d;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      wd    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          wd <= '0;
          if (req_d)
            state <= DACC;
          else if (iREN)
            state <= IACC;
        end
        IACC, DACC: begin
          if (ram_state == RS_ERROR) begin
            state <= ERR;
          end else if (!greq) begin
            state <= IDLE;
            wd    <= '0;
          end else if (acc) begin
            state <= IDLE;
          end else if (wd == WD_MAX) begin
            state <= ERR;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        ERR: state <= ERR;
      endcase
    end
  end

  always_comb begin
    ram_REN   = 1'b0;
    ram_WEN   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    unique case (state)
      IACC: begin
        ram_REN  = 1'b1;
        ram_addr = iaddr;
      end
      DACC: begin
        ram_WEN   = dWEN;
        ram_REN   = dREN & ~dWEN;
        ram_addr  = daddr;
        ram_store = dstore;
      end
      default: ;
    endcase
  end

  // Waits follow the raw enables, so ERR stalls any requester forever
  assign iwait   = iREN  & ~((state == IACC) & acc);
  assign dwait   = req_d & ~((state == DACC) & acc);
  assign iload   = i_done ? ram_load : '0;
  assign dload   = d_done ? ram_load : '0;
  assign mem_err = (state == ERR);

`ifdef MEM_ARB_STATS_EN
  logic [31:0] icnt;
  logic [31:0] dcnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      icnt <= '0;
      dcnt <= '0;
    end else begin
      if (i_done)
        icnt <= icnt + 32'd1;
      if (d_done)
        dcnt <= dcnt + 32'd1;
    end
  end

  assign iaccess_cnt = icnt;
  assign daccess_cnt = dcnt;
`else
  assign iaccess_cnt = '0;
  assign daccess_cnt = '0;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed plan plus random traffic
// against an ownership-based reference model.
module tb_memory_arbiter;

  localparam int TO = 16;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        iwait, dwait;
  logic [31:0] iload, dload;
  logic        ram_REN, ram_WEN;
  logic [31:0] ram_addr, ram_store, ram_load;
  logic [1:0]  ram_state;
  logic        mem_err;
  logic [31:0] iaccess_cnt, daccess_cnt;

  int ncmp = 0;
  int nfail = 0;

  // model: who owns the RAM (0 none, 1 fetch, 2 data, 3 error)
  int          m_own;
  int          m_wait;
  int unsigned m_ic, m_dc;

  memory_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ram_REN(ram_REN), .ram_WEN(ram_WEN),
    .ram_addr(ram_addr), .ram_store(ram_store),
    .ram_load(ram_load), .ram_state(ram_state),
    .mem_err(mem_err),
    .iaccess_cnt(iaccess_cnt), .daccess_cnt(daccess_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int unsigned v);
`ifdef MEM_ARB_STATS_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  task automatic cyc();
    logic rq_d, acc, e_rr, e_rw, own_req;
    logic [31:0] e_ra, e_rs;
    int n_own, n_wait;
    #2;
    rq_d = dREN | dWEN;
    acc  = (ram_state == 2'd2);
    e_rr = (m_own == 1) || (m_own == 2 && dREN && !dWEN);
    e_rw = (m_own == 2) && dWEN;
    e_ra = (m_own == 1) ? iaddr : (m_own == 2) ? daddr : 32'd0;
    e_rs = (m_own == 2) ? dstore : 32'd0;
    own_req = (m_own == 1) ? iREN : rq_d;
    chk("iwait", iwait, iREN && !(m_own == 1 && acc));
    chk("dwait", dwait, rq_d && !(m_own == 2 && acc));
    chk("iload", iload, (m_own == 1 && acc && iREN) ? ram_load : 0);
    chk("dload", dload, (m_own == 2 && acc && rq_d) ? ram_load : 0);
    chk("ram_REN", ram_REN, e_rr);
    chk("ram_WEN", ram_WEN, e_rw);
    chk("ram_addr", ram_addr, e_ra);
    chk("ram_store", ram_store, e_rs);
    chk("mem_err", mem_err, m_own == 3);
    chk("iaccess_cnt", iaccess_cnt, cnt_exp(m_ic));
    chk("daccess_cnt", daccess_cnt, cnt_exp(m_dc));
    n_own = m_own;
    n_wait = m_wait;
    if (m_own == 0) begin
      n_wait = 0;
      if (rq_d) n_own = 2;
      else if (iREN) n_own = 1;
    end else if (m_own != 3) begin
      if (ram_state == 2'd3) n_own = 3;
      else if (!own_req) begin n_own = 0; n_wait = 0; end
      else if (acc) begin
        n_own = 0;
        if (m_own == 1) m_ic++;
        else m_dc++;
      end else if (m_wait == TO - 1) n_own = 3;
      else n_wait = m_wait + 1;
    end
    @(posedge CLK);
    m_own = n_own;
    m_wait = n_wait;
    @(negedge CLK);
  endtask

  task automatic idle_in();
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0;
    ram_load = 0; ram_state = 2'd0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    #2;
    chk("rst_mem_err", mem_err, 1'b0);
    chk("rst_ram_REN", ram_REN, 1'b0);
    chk("rst_ram_WEN", ram_WEN, 1'b0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_icnt", iaccess_cnt, 32'd0);
    chk("rst_dcnt", daccess_cnt, 32'd0);
    m_own = 0; m_wait = 0; m_ic = 0; m_dc = 0;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    logic [31:0] dsave;
    nRST = 1'b0;
    idle_in();
    m_own = 0; m_wait = 0; m_ic = 0; m_dc = 0;
    do_reset();

    // lone fetch
    iREN = 1; iaddr = 32'h40;
    cyc();
    ram_state = 2'd2; ram_load = 32'h3C010001;
    #1;
    chk("fetch_iwait", iwait, 1'b0);
    chk("fetch_iload", iload, 32'h3C010001);
    chk("fetch_ren", ram_REN, 1'b1);
    chk("fetch_addr", ram_addr, 32'h40);
    cyc();
    idle_in();
    #1;
    chk("fetch_idle", ram_REN, 1'b0);
    cyc();

    // concurrent lw + fetch, data wins
    iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h100;
    cyc();
    ram_state = 2'd1;
    #1;
    chk("lw_dacc_addr", ram_addr, 32'h100);
    chk("lw_dwait", dwait, 1'b1);
    cyc();
    cyc();
    ram_state = 2'd2; ram_load = 32'h1234_5678;
    #1;
    chk("lw_done_dwait", dwait, 1'b0);
    chk("lw_done_iwait", iwait, 1'b1);
    cyc();
    dREN = 0; ram_state = 2'd0;
    #1;
    chk("lw_gap_ren", ram_REN, 1'b0);
    cyc();
    ram_state = 2'd2; ram_load = 32'hAAAA_0001;
    #1;
    chk("lw_iacc_addr", ram_addr, 32'h44);
    chk("lw_iacc_iwait", iwait, 1'b0);
    cyc();
    idle_in();
    cyc();

    // store with both enables
    dWEN = 1; dREN = 1; dstore = 32'hDEADBEEF; daddr = 32'h200;
    cyc();
    ram_state = 2'd1;
    #1;
    chk("sw_wen", ram_WEN, 1'b1);
    chk("sw_ren", ram_REN, 1'b0);
    chk("sw_store", ram_store, 32'hDEADBEEF);
    cyc();
    ram_state = 2'd2;
    cyc();
    idle_in();
    cyc();
`ifdef MEM_ARB_STATS_EN
    chk("stats_i", iaccess_cnt, 32'd2);
    chk("stats_d", daccess_cnt, 32'd2);
`else
    chk("stats_off_i", iaccess_cnt, 32'd0);
    chk("stats_off_d", daccess_cnt, 32'd0);
`endif

    // abort mid-DACC
    dsave = daccess_cnt;
    dREN = 1; daddr = 32'h300;
    cyc();
    ram_state = 2'd1;
    cyc();
    dREN = 0;
    cyc();
    #1;
    chk("abort_idle", ram_REN, 1'b0);
    chk("abort_cnt", daccess_cnt, dsave);
    cyc();

    // RAM error in DACC
    dREN = 1;
    cyc();
    ram_state = 2'd3;
    cyc();
    #1;
    chk("ramerr_flag", mem_err, 1'b1);
    cyc();
    idle_in();
    do_reset();

    // watchdog timeout: IDLE cycle then TO busy IACC cycles
    iREN = 1; iaddr = 32'h80; ram_state = 2'd1;
    for (int i = 0; i < TO + 1; i++) cyc();
    #1;
    chk("to_err", mem_err, 1'b1);
    chk("to_iwait", iwait, 1'b1);
    chk("to_ren", ram_REN, 1'b0);
    cyc();
    idle_in();
    do_reset();
    #1;
    chk("to_clear", mem_err, 1'b0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        iREN = $urandom_range(0, 1) == 1;
        dREN = $urandom_range(0, 2) == 0;
        dWEN = $urandom_range(0, 3) == 0;
        iaddr = $urandom;
        daddr = $urandom;
        dstore = $urandom;
      end
      ram_load = $urandom;
      ram_state = ($urandom_range(0, 63) == 0) ? 2'd3
                : 2'($urandom_range(0, 2));
      cyc();
      if (m_own == 3 && $urandom_range(0, 3) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
